hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Hazard/stall controller that sequences the IF/ID and ID/EX pipeline registers and the PC.
//  Detects load-use hazards and taken branches resolved in EX, and runs a multi-cycle
//  mul/div unit through a start/done handshake, holding the front end while it runs.
//  Produces PC/IF_ID write enables and bubble/flush strobes, and keeps stall/flush counters.
// PARAMETERS
//  REG_W       5    register-specifier width
//  CNT_W       32   width of the stall and flush performance counters
//  MD_TIMEOUT  40   maximum MD_WAIT cycles before a forced release
// PORTS
//  Clk            in   1      clock, rising edge
//  Reset          in   1      asynchronous, active-high
//  IF_ID_rs       in   REG_W  rs of the instruction in ID
//  IF_ID_rt       in   REG_W  rt of the instruction in ID
//  IF_ID_usesRt   in   1      ID instruction reads rt as a source
//  ID_EX_MemRead  in   1      EX-stage instruction is a load
//  ID_EX_rt       in   REG_W  load destination in EX
//  EX_BranchTaken in   1      branch/jump in EX resolved taken this cycle
//  MD_start       in   1      ID instruction is a multi-cycle mul/div
//  MD_done        in   1      mul/div result ready (1-cycle pulse)
//  PCWrite        out  1      PC update enable
//  IF_ID_Write    out  1      IF/ID register load enable
//  IF_ID_Flush    out  1      IF/ID register cleared to NOP
//  ID_EX_Flush    out  1      ID/EX control fields zeroed (bubble)
//  MD_go          out  1      1-cycle start pulse to the mul/div unit
//  MD_busy        out  1      high while in MD_WAIT
//  md_timeout     out  1      sticky flag: a forced timeout release occurred
//  stall_count    out  CNT_W  cycles with PCWrite=0 outside reset
//  flush_count    out  CNT_W  cycles with IF_ID_Flush=1 outside reset
// BEHAVIOUR
//  - FSM states: RUN, MD_WAIT. State and counters are registers; strobes are Mealy
//    outputs decoded from state and inputs.
//  - Reset asserted: state=RUN, md_timeout=0, counters=0, timeout counter=0.
//    PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, MD_go=0, MD_busy=0.
//  - load_use = ID_EX_MemRead & (ID_EX_rt!=0) &
//    ((ID_EX_rt==IF_ID_rs) | (IF_ID_usesRt & ID_EX_rt==IF_ID_rt)).
//  - RUN, priority order (highest first):
//    1) EX_BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1.
//       Load-use and MD_start are ignored this cycle. Stay in RUN.
//    2) load_use: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Exactly 1 bubble per hazard.
//    3) MD_start: MD_go=1, PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
//       Go to MD_WAIT; timeout counter cleared.
//    4) none: PCWrite=1, IF_ID_Write=1, all flushes 0.
//  - MD_WAIT: MD_busy=1, PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 every cycle.
//    Timeout counter increments each cycle.
//    - MD_done=1: PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0 that same cycle
//      (the mul/div instruction advances). Next state RUN.
//    - Timeout counter reaches MD_TIMEOUT-1 without MD_done: same release as MD_done,
//      plus md_timeout<=1.
//    - EX_BranchTaken cannot occur in MD_WAIT (EX holds bubbles); it is ignored if seen.
//    - MD_done seen in RUN is ignored.
//  - Counters wrap modulo 2^CNT_W. stall_count increments on any non-reset cycle with
//    PCWrite=0; flush_count increments on any non-reset cycle with IF_ID_Flush=1.
//  - Reset mid-MD_WAIT returns to RUN immediately (async). No MD_go is reissued.
//  - Register 0 never creates a hazard.
// STRUCTURE
//  - Shared package/header (pipeline_defs): REG_W, state encodings ST_RUN=1'b0,
//    ST_MD_WAIT=1'b1.
//  - One sub-module: perf_counter (CNT_W-bit, async reset, inc enable),
//    instantiated twice for stall_count and flush_count.
//  - Hazard compare, FSM and output decode stay in this module.
// TESTING
//  1) Reset high 3 cycles -> PCWrite=0, IF_ID_Flush=1, ID_EX_Flush=1, counters=0.
//     After release with idle inputs -> PCWrite=1, IF_ID_Write=1.
//  2) ID_EX_MemRead=1, ID_EX_rt=8, IF_ID_rs=8 for 1 cycle -> 1 cycle of PCWrite=0,
//     ID_EX_Flush=1; stall_count=1. Repeat with rt=0 -> no stall.
//  3) Load-use and EX_BranchTaken same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1;
//     flush_count=1, stall_count unchanged.
//  4) MD_start, MD_done 5 cycles later -> MD_go pulse 1 cycle, MD_busy=1 for 5 cycles,
//     PCWrite=1 on the MD_done cycle, stall_count=6.
//  5) MD_start with no MD_done, MD_TIMEOUT=40 -> release after 40 MD_WAIT cycles,
//     md_timeout=1 and still 1 after 100 more cycles.
//  6) Reset pulse during MD_WAIT -> state RUN and MD_busy=0 immediately;
//     after release, normal RUN outputs with no MD_go.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Purpose: shared pipeline definitions for the hazard/stall controller (FSM encodings, strobe bundle).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_stall_ctrl_pkg;

    // Default register-specifier width of the pipeline
    localparam int DEF_REG_W = 5;

    // Controller FSM encodings
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    // Bundle of front-end strobes produced each cycle
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic md_go;
        logic md_busy;
    } ctrl_t;

    // While reset is held: front end frozen, both pipeline registers forced to NOP
    localparam ctrl_t CTRL_RESET = '{
        pc_write:    1'b0,
        if_id_write: 1'b0,
        if_id_flush: 1'b1,
        id_ex_flush: 1'b1,
        md_go:       1'b0,
        md_busy:     1'b0
    };

    // Normal flow: PC and IF/ID advance, nothing flushed
    localparam ctrl_t CTRL_ADVANCE = '{
        pc_write:    1'b1,
        if_id_write: 1'b1,
        if_id_flush: 1'b0,
        id_ex_flush: 1'b0,
        md_go:       1'b0,
        md_busy:     1'b0
    };

    // Front end held, bubble inserted into ID/EX
    localparam ctrl_t CTRL_BUBBLE = '{
        pc_write:    1'b0,
        if_id_write: 1'b0,
        if_id_flush: 1'b0,
        id_ex_flush: 1'b1,
        md_go:       1'b0,
        md_busy:     1'b0
    };

endpackage

// File: rtl/perf_counter.sv
// Purpose: free-running performance counter, wraps modulo 2^CNT_W.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; counts every enabled cycle.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: add one when enabled, natural wrap at the top
    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Purpose: sequences PC / IF-ID / ID-EX for load-use stalls, taken branches and a multi-cycle mul/div.
// Latency: strobes are combinational (Mealy) from state and inputs; state/counters update on the next edge.
// Backpressure: holds PC and IF/ID for one bubble per load-use hazard and for the whole mul/div run.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W      = DEF_REG_W,
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 40
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic             IF_ID_usesRt,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_rt,
    input  logic             EX_BranchTaken,
    input  logic             MD_start,
    input  logic             MD_done,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MD_go,
    output logic             MD_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Wide enough to hold MD_TIMEOUT-1 with headroom
    localparam int TMO_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

    logic [0:0]       state_d, state_q;
    logic [TMO_W-1:0] tmo_d, tmo_q;
    logic             md_timeout_d, md_timeout_q;

    logic  load_use;
    logic  tmo_hit;
    ctrl_t ctrl_run;   // decode as if reset were not asserted
    ctrl_t ctrl_out;

    // Load-use hazard: the load in EX writes a register the ID instruction reads; r0 is never a hazard
    always_comb begin
        load_use = ID_EX_MemRead && (ID_EX_rt != '0) &&
                   ((ID_EX_rt == IF_ID_rs) || (IF_ID_usesRt && (ID_EX_rt == IF_ID_rt)));
    end

    assign tmo_hit = (tmo_q == TMO_LAST);

    // FSM next state, timeout tracking and strobe decode
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        md_timeout_d = md_timeout_q;
        ctrl_run     = CTRL_ADVANCE;

        case (state_q)
            ST_RUN: begin
                if (EX_BranchTaken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed; fetch continues from target.
                    // Any hazard or mul/div request belongs to a squashed instruction.
                    ctrl_run             = CTRL_ADVANCE;
                    ctrl_run.if_id_flush = 1'b1;
                    ctrl_run.id_ex_flush = 1'b1;
                end else if (load_use) begin
                    // One bubble; the load reaches MEM next cycle so the hazard clears by itself
                    ctrl_run = CTRL_BUBBLE;
                end else if (MD_start) begin
                    ctrl_run       = CTRL_BUBBLE;
                    ctrl_run.md_go = 1'b1;
                    state_d        = ST_MD_WAIT;
                    tmo_d          = '0;
                end else begin
                    ctrl_run = CTRL_ADVANCE;
                end
            end

            ST_MD_WAIT: begin
                // EX only holds bubbles here, so a taken branch cannot be genuine and is ignored
                ctrl_run         = CTRL_BUBBLE;
                ctrl_run.md_busy = 1'b1;
                tmo_d            = tmo_q + TMO_W'(1);
                if (MD_done || tmo_hit) begin
                    // Release: the mul/div instruction advances out of ID this cycle
                    ctrl_run.pc_write    = 1'b1;
                    ctrl_run.if_id_write = 1'b1;
                    ctrl_run.id_ex_flush = 1'b0;
                    state_d              = ST_RUN;
                    tmo_d                = '0;
                    if (!MD_done) begin
                        md_timeout_d = 1'b1;
                    end
                end
            end

            default: begin
                ctrl_run = CTRL_BUBBLE;
                state_d  = ST_RUN;
                tmo_d    = '0;
            end
        endcase
    end

    // Reset overrides every strobe so the pipeline registers hold NOPs while in reset
    always_comb begin
        ctrl_out = ctrl_run;
        if (Reset) begin
            ctrl_out = CTRL_RESET;
        end
    end

    // State, timeout counter and sticky timeout flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_RUN;
            tmo_q        <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Counters sit in reset while Reset is high, so the non-reset decode is enough for their enables
    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (Clk),
        .rst    (Reset),
        .inc_en (!ctrl_run.pc_write),
        .count  (stall_count)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (Clk),
        .rst    (Reset),
        .inc_en (ctrl_run.if_id_flush),
        .count  (flush_count)
    );

    assign PCWrite     = ctrl_out.pc_write;
    assign IF_ID_Write = ctrl_out.if_id_write;
    assign IF_ID_Flush = ctrl_out.if_id_flush;
    assign ID_EX_Flush = ctrl_out.id_ex_flush;
    assign MD_go       = ctrl_out.md_go;
    assign MD_busy     = ctrl_out.md_busy;
    assign md_timeout  = md_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose: directed bench for hazard_stall_ctrl with a queue-based scoreboard.
// Latency: each stimulus cycle pushes one expectation, checked at the following falling edge.
// Backpressure: n/a.
module tb_hazard_stall_ctrl;

    logic        Clk;
    logic        Reset;
    logic [4:0]  IF_ID_rs, IF_ID_rt, ID_EX_rt;
    logic        IF_ID_usesRt, ID_EX_MemRead, EX_BranchTaken, MD_start, MD_done;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_go, MD_busy, md_timeout;
    logic [31:0] stall_count, flush_count;

    hazard_stall_ctrl #(.REG_W(5), .CNT_W(32), .MD_TIMEOUT(40)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .IF_ID_rs       (IF_ID_rs),
        .IF_ID_rt       (IF_ID_rt),
        .IF_ID_usesRt   (IF_ID_usesRt),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_rt       (ID_EX_rt),
        .EX_BranchTaken (EX_BranchTaken),
        .MD_start       (MD_start),
        .MD_done        (MD_done),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .MD_go          (MD_go),
        .MD_busy        (MD_busy),
        .md_timeout     (md_timeout),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Output vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_go, MD_busy, md_timeout}
    localparam logic [6:0] O_RST  = 7'b0011000;
    localparam logic [6:0] O_RUN  = 7'b1100000;
    localparam logic [6:0] O_LU   = 7'b0001000;
    localparam logic [6:0] O_BR   = 7'b1111000;
    localparam logic [6:0] O_GO   = 7'b0001100;
    localparam logic [6:0] O_WAIT = 7'b0001010;
    localparam logic [6:0] O_REL  = 7'b1100010;
    localparam logic [6:0] O_TMO  = 7'b0000001;

    typedef struct {
        string       nm;
        logic [6:0]  o;
        logic [31:0] s;
        logic [31:0] f;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;
    logic [6:0]  got;

    assign got = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_go, MD_busy, md_timeout};

    // Monitor: outputs are presented every cycle; compare against the oldest pending expectation
    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if (got !== e.o || stall_count !== e.s || flush_count !== e.f) begin
                bad++;
                $display("FAIL %s: got o=%b stall=%0d flush=%0d, want o=%b stall=%0d flush=%0d",
                         e.nm, got, stall_count, flush_count, e.o, e.s, e.f);
            end
        end
    end

    // Drive one cycle of inputs and queue the hand-computed outputs for it.
    // Counter expectations: PCWrite=0 / IF_ID_Flush=1 in a non-reset cycle shows up one edge later.
    task automatic step(input logic rst, input logic memrd, input logic [4:0] ex_rt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic br, input logic mds, input logic mdd,
                        input logic [6:0] eo, input string nm);
        exp_t e;
        Reset          = rst;
        ID_EX_MemRead  = memrd;
        ID_EX_rt       = ex_rt;
        IF_ID_rs       = rs;
        IF_ID_rt       = rt;
        IF_ID_usesRt   = uses;
        EX_BranchTaken = br;
        MD_start       = mds;
        MD_done        = mdd;
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end
        e.nm = nm;
        e.o  = eo;
        e.s  = m_stall;
        e.f  = m_flush;
        sb_q.push_back(e);
        if (!rst) begin
            if (!eo[6]) m_stall = m_stall + 1;
            if (eo[4])  m_flush = m_flush + 1;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic [6:0] eo, input string nm);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, eo, nm);
    endtask

    initial begin
        Reset = 1'b1; ID_EX_MemRead = 0; ID_EX_rt = 0; IF_ID_rs = 0; IF_ID_rt = 0;
        IF_ID_usesRt = 0; EX_BranchTaken = 0; MD_start = 0; MD_done = 0;
        @(posedge Clk);
        #1;

        // 1) reset held 3 cycles, then idle flow
        for (int i = 0; i < 3; i++)
            step(1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RST, "reset_hold");
        idle(O_RUN, "idle_after_reset");
        idle(O_RUN, "idle_after_reset2");

        // 2) load-use on rs gives exactly one bubble; r0 never stalls
        step(0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, O_LU,  "load_use_rs");
        idle(O_RUN, "after_load_use");            // stall_count now 1
        step(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, O_RUN, "load_r0_no_stall");
        idle(O_RUN, "stall_still_1");

        // 3) taken branch outranks load-use
        step(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0, O_BR,  "branch_over_load_use");
        idle(O_RUN, "after_branch");              // flush_count 1, stall_count 1

        // 4) mul/div with done 5 cycles after start
        step(0, 0, 5'd0, 5'd1, 5'd2, 1, 0, 1, 0, O_GO,  "md_go");
        for (int i = 0; i < 4; i++)
            idle(O_WAIT, "md_wait");
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, O_REL, "md_done_release");
        idle(O_RUN, "after_md_stall_6");          // stall_count 6

        // Extra patterns: rt match only counts when rt is a source
        step(0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, O_RUN, "rt_match_not_used");
        step(0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, O_LU,  "rt_match_used");
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, O_RUN, "md_done_in_run_ignored");
        // load-use outranks MD_start; mul/div issues the following cycle
        step(0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0, O_LU,  "load_use_over_md_start");
        step(0, 0, 5'd0, 5'd7, 5'd0, 0, 0, 1, 0, O_GO,  "md_go_after_bubble");
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_WAIT, "branch_in_wait_ignored");
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, O_REL, "md_done_release2");
        idle(O_RUN, "run_after_md2");

        // 5) timeout: 40 MD_WAIT cycles, release on the 40th, flag sticky
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_GO,  "md_go_timeout");
        for (int i = 0; i < 39; i++)
            idle(O_WAIT, "md_wait_timeout");
        idle(O_REL, "timeout_release");
        for (int i = 0; i < 100; i++)
            idle(O_RUN | O_TMO, "timeout_sticky");

        // 6) reset in the middle of MD_WAIT
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_GO | O_TMO,   "md_go_before_reset");
        idle(O_WAIT | O_TMO, "md_wait_before_reset");
        idle(O_WAIT | O_TMO, "md_wait_before_reset2");
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RST, "reset_mid_wait");
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RST, "reset_mid_wait2");
        for (int i = 0; i < 3; i++)
            idle(O_RUN, "run_after_reset_no_go");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge Clk);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
